// File: rtl/sb_io_pad.sv
// Bidirectional pad cell with SB_IO-style PIN_TYPE decoding: combinational, registered, latched and DDR paths.
// Latency: direct paths are combinational; registered paths take one clk edge (rising, or falling for DDR low phase).
// Backpressure: none; clk_en freezes every register, and latch_input_value freezes the input path in latch modes.
//
// Ports:
//   clk, rst_n, clk_en        single clock (both edges used), async active-low reset, register enable
//   package_pin               physical pad (driven when the OE mode says so, otherwise released)
//   output_enable             tristate request, used directly or through oe_q
//   d_out_0 / d_out_1         output data for rising / falling phase
//   latch_input_value         freezes the input path in modes 10 and 11
//   d_in_0 / d_in_1           input data for rising (or direct) / falling phase
module sb_io_pad #(
    parameter logic [5:0] PIN_TYPE = 6'b101001,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    inout  wire  package_pin,
    input  logic output_enable,
    input  logic d_out_0,
    input  logic d_out_1,
    input  logic latch_input_value,
    output logic d_in_0,
    output logic d_in_1
);

    localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];
    localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
    localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];

    logic pad;
    logic in_r;
    logic in_f;
    logic out_r;
    logic out_f;
    logic oe_q;
    logic in_hold;
    logic in_upd;
    logic dval;
    logic drive;

    // The input path always observes the pad, including the value this cell drives itself.
    assign pad = package_pin;

    // Registered+latch mode freezes both input capture registers while the latch request is high.
    assign in_upd = !((IN_MODE == 2'b10) && latch_input_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_r  <= 1'b0;
            out_r <= 1'b0;
            oe_q  <= 1'b0;
        end else if (clk_en) begin
            out_r <= d_out_0;
            oe_q  <= output_enable;
            if (in_upd) begin
                in_r <= pad;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_f  <= 1'b0;
            out_f <= 1'b0;
        end else if (clk_en) begin
            out_f <= d_out_1;
            if (in_upd) begin
                in_f <= pad;
            end
        end
    end

    // Transparent while latch_input_value is low, frozen from its rising transition on.
    always_latch begin
        if (!rst_n) begin
            in_hold <= 1'b0;
        end else if (!latch_input_value) begin
            in_hold <= pad;
        end
    end

    always_comb begin
        dval = 1'b0;
        case (OUT_MODE)
            2'b00:   dval = clk ? out_r : out_f;
            2'b01:   dval = out_r;
            2'b10:   dval = d_out_0;
            default: dval = ~out_r;
        endcase
    end

    always_comb begin
        drive = 1'b0;
        case (OE_MODE)
            2'b00:   drive = 1'b0;
            2'b01:   drive = 1'b1;
            2'b10:   drive = output_enable;
            default: drive = oe_q;
        endcase
    end

    assign package_pin = drive ? dval : 1'bz;

    generate
        if (PULLUP) begin : g_pullup
            pullup u_pullup (package_pin);
        end
    endgenerate

    always_comb begin
        d_in_0 = 1'b0;
        d_in_1 = 1'b0;
        case (IN_MODE)
            2'b00, 2'b10: begin
                d_in_0 = in_r;
                d_in_1 = in_f;
            end
            2'b01: begin
                d_in_0 = pad;
            end
            default: begin
                d_in_0 = latch_input_value ? in_hold : pad;
            end
        endcase
    end

endmodule

// File: tb/tb_sb_io_pad.sv
// Bench for sb_io_pad: eight cells with different PIN_TYPEs share one stimulus set and are checked against a model.
// Latency: outputs checked 1 time unit after every clock edge and after every input change.
// Backpressure: not applicable; external pad drivers only drive when the model says the cell has released the pad.
module tb_sb_io_pad;

    localparam int NI = 8;
    // Cell 4 carries the pull-up; cells whose registered inputs see the pad never have it switch at a clock edge.
    localparam logic [5:0] PT [NI] = '{
        6'b101001,   // 0 default: oe direct, data direct, input direct
        6'b010100,   // 1 always drive, registered out, registered in (loopback)
        6'b010001,   // 2 always drive, DDR out, direct in
        6'b110101,   // 3 registered oe, registered out, direct in
        6'b000011,   // 4 never drive, latch input, pull-up
        6'b000010,   // 5 never drive, registered+latch input
        6'b011101,   // 6 always drive, inverted registered out, direct in
        6'b000000    // 7 never drive, registered/DDR input
    };

    logic clk;
    logic rst_n;
    logic clk_en;
    logic oe;
    logic d0;
    logic d1;
    logic latch;
    logic [NI-1:0] ext_val;
    logic [NI-1:0] float_e;
    logic [NI-1:0] ext_en;
    logic [NI-1:0] m_drv;
    wire  [NI-1:0] pad_rd;
    wire  [NI-1:0] din0;
    wire  [NI-1:0] din1;

    // Model state: what each cell has captured, by rule, at its enabled clock edges.
    logic [NI-1:0] m_in_r;
    logic [NI-1:0] m_in_f;
    logic [NI-1:0] m_out_r;
    logic [NI-1:0] m_out_f;
    logic [NI-1:0] m_oe_q;
    logic [NI-1:0] m_hold;
    logic [NI-1:0] pre;

    int n_chk;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wire pad_w;
        assign pad_w     = ext_en[g] ? ext_val[g] : 1'bz;
        assign pad_rd[g] = pad_w;
        sb_io_pad #(
            .PIN_TYPE(PT[g]),
            .PULLUP  (g == 4)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .clk_en           (clk_en),
            .package_pin      (pad_w),
            .output_enable    (oe),
            .d_out_0          (d0),
            .d_out_1          (d1),
            .latch_input_value(latch),
            .d_in_0           (din0[g]),
            .d_in_1           (din1[g])
        );
    end

    // Whether the cell should be driving its pad; the external driver takes over otherwise.
    always_comb begin
        m_drv  = '0;
        ext_en = '0;
        for (int i = 0; i < NI; i++) begin
            case (PT[i][5:4])
                2'b00:   m_drv[i] = 1'b0;
                2'b01:   m_drv[i] = 1'b1;
                2'b10:   m_drv[i] = oe;
                default: m_drv[i] = m_oe_q[i];
            endcase
            ext_en[i] = !m_drv[i] && !float_e[i];
        end
    end

    function automatic logic f_pad(int i, logic ph);
        logic v;
        if (m_drv[i]) begin
            case (PT[i][3:2])
                2'b00:   v = ph ? m_out_r[i] : m_out_f[i];
                2'b01:   v = m_out_r[i];
                2'b10:   v = d0;
                default: v = ~m_out_r[i];
            endcase
        end else if (!float_e[i]) begin
            v = ext_val[i];
        end else begin
            v = 1'b1;
        end
        return v;
    endfunction

    function automatic logic f_din0(int i);
        case (PT[i][1:0])
            2'b00, 2'b10: return m_in_r[i];
            2'b01:        return f_pad(i, clk);
            default:      return latch ? m_hold[i] : f_pad(i, clk);
        endcase
    endfunction

    function automatic logic f_din1(int i);
        if (PT[i][1:0] == 2'b00 || PT[i][1:0] == 2'b10) return m_in_f[i];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s.u%0d.pad", ph, i), pad_rd[i], f_pad(i, clk));
            check($sformatf("%s.u%0d.d_in_0", ph, i), din0[i], f_din0(i));
            check($sformatf("%s.u%0d.d_in_1", ph, i), din1[i], f_din1(i));
        end
    endtask

    task automatic model_reset();
        m_in_r  = '0;
        m_in_f  = '0;
        m_out_r = '0;
        m_out_f = '0;
        m_oe_q  = '0;
        m_hold  = '0;
    endtask

    task automatic track_hold();
        if (rst_n && !latch) begin
            for (int i = 0; i < NI; i++) m_hold[i] = f_pad(i, clk);
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < NI; i++) pre[i] = f_pad(i, clk);
    endtask

    task automatic model_rise();
        if (rst_n && clk_en) begin
            m_out_r = {NI{d0}};
            m_oe_q  = {NI{oe}};
            for (int i = 0; i < NI; i++) begin
                if (!(PT[i][1:0] == 2'b10 && latch)) m_in_r[i] = pre[i];
            end
        end
    endtask

    task automatic model_fall();
        if (rst_n && clk_en) begin
            m_out_f = {NI{d1}};
            for (int i = 0; i < NI; i++) begin
                if (!(PT[i][1:0] == 2'b10 && latch)) m_in_f[i] = pre[i];
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b1;
        clk_en  = 1'b0;
        oe      = 1'b0;
        d0      = 1'b0;
        d1      = 1'b0;
        latch   = 1'b0;
        ext_val = '0;
        float_e = '0;
        model_reset();
        pre = '0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");

        for (int c = 0; c < 400; c++) begin
            // Low phase: pad-side stimulus first, so a latch closing later sees a settled pad.
            ext_val    = NI'($urandom);
            float_e    = '0;
            float_e[4] = ($urandom_range(0, 2) == 0);
            #1;
            track_hold();
            oe     = 1'($urandom_range(0, 1));
            d0     = 1'($urandom_range(0, 1));
            d1     = 1'($urandom_range(0, 1));
            clk_en = ($urandom_range(0, 3) != 0);
            latch  = ($urandom_range(0, 2) == 0);
            if (!rst_n) begin
                if ($urandom_range(0, 1) == 1) rst_n = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
            end
            #1;
            if (!rst_n) model_reset();
            track_hold();
            check_all("low");

            snapshot();
            @(posedge clk);
            model_rise();
            #1;
            track_hold();
            check_all("rise");

            // Reset asserted between edges must take effect immediately.
            if (rst_n && $urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("arst");
            end

            snapshot();
            @(negedge clk);
            model_fall();
            #1;
            track_hold();
            check_all("fall");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
